// File: rtl/exe_pkg.sv
// ============================================================================
// Module      : exe_pkg
// Description : Shared ALU opcodes, operand-mux selects, multiplier FSM
//               encoding and the ALU evaluation function for the EXE stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_pkg;

    localparam logic [4:0] c_aluc_addu = 5'd0;
    localparam logic [4:0] c_aluc_add  = 5'd1;
    localparam logic [4:0] c_aluc_subu = 5'd2;
    localparam logic [4:0] c_aluc_sub  = 5'd3;
    localparam logic [4:0] c_aluc_and  = 5'd4;
    localparam logic [4:0] c_aluc_or   = 5'd5;
    localparam logic [4:0] c_aluc_xor  = 5'd6;
    localparam logic [4:0] c_aluc_nor  = 5'd7;
    localparam logic [4:0] c_aluc_slt  = 5'd8;
    localparam logic [4:0] c_aluc_sltu = 5'd9;
    localparam logic [4:0] c_aluc_sll  = 5'd10;
    localparam logic [4:0] c_aluc_srl  = 5'd11;
    localparam logic [4:0] c_aluc_sra  = 5'd12;
    localparam logic [4:0] c_aluc_lui  = 5'd13;

    localparam logic       c_mux1_rs    = 1'b0;
    localparam logic       c_mux1_shamt = 1'b1;
    localparam logic [1:0] c_mux2_rt    = 2'd0;
    localparam logic [1:0] c_mux2_imm   = 2'd1;
    localparam logic [1:0] c_mux2_immu  = 2'd2;
    localparam logic [1:0] c_mux2_zero  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    function automatic logic [31:0] alu_calc(input logic [4:0]  aluc,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (aluc)
            c_aluc_addu, c_aluc_add: r = a + b;
            c_aluc_subu, c_aluc_sub: r = a - b;
            c_aluc_and:  r = a & b;
            c_aluc_or:   r = a | b;
            c_aluc_xor:  r = a ^ b;
            c_aluc_nor:  r = ~(a | b);
            c_aluc_slt:  r = {31'h0, ($signed(a) < $signed(b))};
            c_aluc_sltu: r = {31'h0, (a < b)};
            c_aluc_sll:  r = b << a[4:0];
            c_aluc_srl:  r = b >> a[4:0];
            c_aluc_sra:  r = $unsigned($signed(b) >>> a[4:0]);
            c_aluc_lui:  r = {b[15:0], 16'h0};
            default:     r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exe_mul_iter.sv
// ============================================================================
// Module      : mul_iter
// Description : Radix-2 shift-add multiplier, one partial product per cycle,
//               32 BUSY cycles regardless of operand values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    mul_state_t  r_state;
    mul_state_t  w_state_nxt;
    logic [4:0]  r_count;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_count == 5'd31) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Multiplicand walks left while the multiplier walks right; only the low
    // 32 bits of the product are ever needed, so 32-bit registers suffice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 5'd0;
            r_mcand  <= 32'h0;
            r_mplier <= 32'h0;
            r_acc    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count  <= 5'd0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= 32'h0;
                    end
                end
                ST_BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign done = (r_state == ST_DONE);
    assign p    = r_acc;

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// Module      : exe_stage
// Description : Pipeline EXE stage: ALU, JAL link, iterative MUL with stall,
//               overflow suppression and the EXE/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_lw,
    input  logic        exe_jal,
    input  logic        exe_mul,
    input  logic [4:0]  exe_aluc,
    input  logic        exe_aluc_mux1_select,
    input  logic [1:0]  exe_aluc_mux2_select,
    input  logic [31:0] exe_npc,
    input  logic [31:0] exe_shamt,
    input  logic [31:0] exe_imm,
    input  logic [31:0] exe_immu,
    input  logic [31:0] exe_rs_reg,
    input  logic [31:0] exe_rt_reg,
    input  logic        exe_dm_w_ena,
    input  logic [31:0] exe_dm_wdata,
    input  logic        exe_rf_w_ena,
    input  logic [4:0]  exe_rf_waddr,
    output logic        stall,
    output logic [31:0] fwd_data,
    output logic        mem_lw,
    output logic        mem_dm_w_ena,
    output logic        mem_rf_w_ena,
    output logic        mem_ovf,
    output logic [31:0] mem_result,
    output logic [31:0] mem_dm_wdata,
    output logic [4:0]  mem_rf_waddr
);

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_prod;
    logic [31:0] w_result;
    logic        w_alu_ovf;
    logic        w_ovf;
    logic        w_mul_busy;
    logic        w_mul_done;
    logic        w_mul_idle;
    logic        w_stall;

    mul_iter u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (exe_mul),
        .a     (exe_rs_reg),
        .b     (exe_rt_reg),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_prod)
    );

    always_comb begin
        w_op_a = (exe_aluc_mux1_select == c_mux1_shamt) ? exe_shamt : exe_rs_reg;
        w_op_b = 32'h0;
        case (exe_aluc_mux2_select)
            c_mux2_rt:   w_op_b = exe_rt_reg;
            c_mux2_imm:  w_op_b = exe_imm;
            c_mux2_immu: w_op_b = exe_immu;
            c_mux2_zero: w_op_b = 32'h0;
            default:     w_op_b = 32'h0;
        endcase
    end

    assign w_alu  = alu_calc(exe_aluc, w_op_a, w_op_b);
    assign w_sum  = w_op_a + w_op_b;
    assign w_diff = w_op_a - w_op_b;

    // Signed overflow: operand signs agree (add) or differ (sub) and the
    // result sign departs from operand A.
    always_comb begin
        w_alu_ovf = 1'b0;
        case (exe_aluc)
            c_aluc_add: w_alu_ovf = (w_op_a[31] == w_op_b[31]) && (w_sum[31]  != w_op_a[31]);
            c_aluc_sub: w_alu_ovf = (w_op_a[31] != w_op_b[31]) && (w_diff[31] != w_op_a[31]);
            default:    w_alu_ovf = 1'b0;
        endcase
    end

    assign w_ovf      = w_alu_ovf & ~exe_jal & ~exe_mul;
    assign w_result   = exe_jal ? exe_npc : (exe_mul ? w_prod : w_alu);
    assign w_mul_idle = ~w_mul_busy & ~w_mul_done;
    assign w_stall    = ~rst & ((w_mul_idle & exe_mul) | w_mul_busy);

    assign stall    = w_stall;
    assign fwd_data = w_stall ? 32'h0 : w_result;

    // EXE/MEM register: a stalled cycle hands a bubble downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_stall) begin
            mem_lw       <= 1'b0;
            mem_dm_w_ena <= 1'b0;
            mem_rf_w_ena <= 1'b0;
            mem_ovf      <= 1'b0;
            mem_result   <= 32'h0;
            mem_dm_wdata <= 32'h0;
            mem_rf_waddr <= 5'd0;
        end else begin
            mem_lw       <= exe_lw;
            mem_dm_w_ena <= exe_dm_w_ena;
            mem_rf_w_ena <= exe_rf_w_ena & ~w_ovf;
            mem_ovf      <= w_ovf;
            mem_result   <= w_result;
            mem_dm_wdata <= exe_dm_wdata;
            mem_rf_waddr <= exe_rf_waddr;
        end
    end

endmodule

`default_nettype wire

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock.
REQ-002 SHALL: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL: exe_lw, exe_jal, exe_mul  input  1 each  instruction class flags from the ID/EXE register.
REQ-004 SHALL: exe_aluc  input  5  ALU opcode.
REQ-005 SHALL: exe_aluc_mux1_select  input  1  operand A: 0 = rs_reg, 1 = shamt.
REQ-006 SHALL: exe_aluc_mux2_select  input  2  operand B: 0 = rt_reg, 1 = imm, 2 = immu, 3 = 0.
REQ-007 SHALL: exe_npc, exe_shamt, exe_imm, exe_immu, exe_rs_reg, exe_rt_reg  input  32 each  datapath operands.
REQ-008 SHALL: exe_dm_w_ena  input  1; exe_dm_wdata  input  32; exe_rf_w_ena  input  1; exe_rf_waddr  input  5  memory and register-file write controls.
REQ-009 SHALL: stall  output  1  holds IF/ID and ID/EXE when high.
REQ-010 SHALL: fwd_data  output  32  combinational EXE result, for forwarding.
REQ-011 SHALL: mem_lw, mem_dm_w_ena, mem_rf_w_ena, mem_ovf  output  1 each; mem_result, mem_dm_wdata  output  32; mem_rf_waddr  output  5; all registered EXE/MEM outputs.

Function
REQ-012 SHALL: ALU opcodes 0 ADDU, 1 ADD, 2 SUBU, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, 10 SLL B by A[4:0], 11 SRL, 12 SRA, 13 LUI (B[15:0], 16'h0); other opcodes return 0.
REQ-013 SHALL: result selection priority is exe_jal (result = exe_npc), then MUL product, then ALU result.
REQ-014 SHALL: for non-MUL instructions, latency is 1 cycle; all mem_* outputs are loaded from the current inputs at the next edge.
REQ-015 SHALL: ADD/SUB signed overflow loads mem_ovf=1 and mem_rf_w_ena=0 for that instruction; otherwise mem_ovf=0.
REQ-016 SHALL: MUL uses a radix-2 shift-add iterative multiplier; the low 32 bits of rs_reg*rt_reg form the result.
REQ-017 SHALL: MUL FSM states are IDLE, BUSY, DONE; IDLE->BUSY when exe_mul=1 (captures operands, count=0); BUSY->DONE when count reaches 31; DONE->IDLE unconditionally.
REQ-018 SHALL: stall = (IDLE & exe_mul) | BUSY; stall is low in DONE.
REQ-019 SHALL: while stall=1, mem_* outputs load a bubble (all 0); a MUL is therefore presented for 34 cycles and produces exactly one MEM entry, at the edge ending DONE.
REQ-020 SHALL: operands 0 or 0xFFFFFFFF still take the full 32 BUSY cycles; there is no early termination.
REQ-021 SHALL: a MUL directly following a MUL (exe_mul still 1 in DONE) is accepted in the following IDLE cycle, not in DONE.
REQ-022 SHALL: fwd_data equals the value that mem_result would load at the next edge.

Reset
REQ-023 SHALL: rst forces state=IDLE, count=0, multiplier registers=0, and all mem_* outputs=0, immediately, including mid-multiply.
REQ-024 SHALL: after rst is released, a MUL that was in progress is restarted from IDLE only if exe_mul is still presented.

Structure
REQ-025 SHALL: the package exe_pkg holds the aluc opcode constants, the mux select constants, and the FSM state encoding.
REQ-026 SHALL: the iterative multiplier (FSM, counter, accumulator) is one sub-module, mul_iter, with start, busy, done, a[31:0], b[31:0], and p[31:0].

Verification
REQ-027 SHALL: ADD 0x7FFFFFFF+1 with rf_w_ena=1 -> next cycle mem_ovf=1, mem_rf_w_ena=0, mem_result=0x80000000.
REQ-028 SHALL: SRA, mux1=1, shamt=4, rt=0xF0000000 -> mem_result=0xFF000000 after 1 cycle; SLT -1<1 -> 1, SLTU -> 0.
REQ-029 SHALL: MUL 0x12345678*3 -> stall high for 33 cycles, mem_* are bubbles throughout, then mem_result=0x369D0368 with mem_rf_w_ena=1 exactly once.
REQ-030 SHALL: back-to-back MUL 0xFFFFFFFF*0xFFFFFFFF then 7*6 -> results 0x00000001 then 0x0000002A, with at least one IDLE cycle between them.
REQ-031 SHALL: rst pulse at BUSY count 10 -> all outputs 0, stall low during rst, a fresh MUL after release gives the correct product.
REQ-032 SHALL: JAL with npc=0x00400008 -> mem_result=0x00400008 after 1 cycle, regardless of exe_aluc.
